// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtraction controller: sequences one full-subtractor slice LSB-first over
// WIDTH cycles and presents the registered difference and final borrow with a done pulse.
module serial_sub_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, diff_q, diff_d;
  logic             br_q, br_d, bout_q, bout_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic             slice_d, slice_bo;
  logic [WIDTH-1:0] res_shift;

  always_comb begin
    slice_d   = a_q[0] ^ b_q[0] ^ br_q;
    slice_bo  = (~a_q[0] & (b_q[0] ^ br_q)) | (b_q[0] & br_q);
    res_shift = (res_q >> 1) | (WIDTH'(slice_d) << (WIDTH - 1));
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          br_d    = borrow_in;
          res_d   = '0;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = slice_bo;
        res_d = res_shift;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastBit) begin
          // Load the outputs from the final slice so they are valid while done is high.
          diff_d  = res_shift;
          bout_d  = slice_bo;
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

  assign ready      = (state_q == StIdle);
  assign busy       = (state_q == StRun);
  assign done       = (state_q == StDone);
  assign diff       = diff_q;
  assign borrow_out = bout_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl: WIDTH=8 and WIDTH=1 instances, vector table,
// control corner cases and back-to-back random operations against an arithmetic model.
module tb_serial_sub_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start8, bin8, ready8, busy8, done8, bo8;
  logic [7:0] a8, b8, diff8;
  logic       start1, bin1, ready1, busy1, done1, bo1;
  logic [0:0] a1, b1, diff1;

  int n_tests = 0;
  int n_fail  = 0;

  serial_sub_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .borrow_in(bin8),
    .ready(ready8), .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8)
  );

  serial_sub_ctrl #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .borrow_in(bin1),
    .ready(ready1), .busy(busy1), .done(done1), .diff(diff1), .borrow_out(bo1)
  );

  typedef struct {
    int a;
    int b;
    int bin;
    int exp_diff;
    int exp_bo;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain integer subtraction reduced modulo 2^w.
  function automatic void ref_sub(input int w, input int a, input int b, input int bin,
                                  output int d, output int bo);
    int t;
    t  = a - b - bin;
    bo = (t < 0) ? 1 : 0;
    d  = (t + (1 << w)) % (1 << w);
  endfunction

  task automatic run_op(input bit w1, input int a, input int b, input int bin,
                        output int d, output int bo, output int lat, output int bcnt);
    int guard = 0;
    while (!(w1 ? ready1 : ready8) && guard < 50) begin
      tick();
      guard++;
    end
    if (w1) begin
      start1 = 1'b1; a1 = a[0]; b1 = b[0]; bin1 = bin[0];
    end else begin
      start8 = 1'b1; a8 = a[7:0]; b8 = b[7:0]; bin8 = bin[0];
    end
    tick();
    start1 = 1'b0;
    start8 = 1'b0;
    check("ready_drop", w1 ? ready1 : ready8, 0);
    lat  = 1;
    bcnt = 0;
    while (!(w1 ? done1 : done8) && lat < 40) begin
      if (w1 ? busy1 : busy8) bcnt++;
      tick();
      lat++;
    end
    if (!(w1 ? done1 : done8)) check("done_timeout", 0, 1);
    d  = w1 ? int'(diff1) : int'(diff8);
    bo = w1 ? int'(bo1) : int'(bo8);
  endtask

  initial begin
    vec_t vecs[7];
    int d, bo, lat, bcnt, ed, ebo, ndone;
    int q_d[$], q_bo[$];
    int accepts, dones, last_acc, cyc;

    vecs[0] = '{200, 55, 0, 145, 0};
    vecs[1] = '{5, 10, 0, 251, 1};
    vecs[2] = '{0, 0, 1, 255, 1};
    vecs[3] = '{8'hAA, 8'hAA, 0, 0, 0};
    vecs[4] = '{255, 0, 0, 255, 0};
    vecs[5] = '{0, 255, 1, 0, 1};
    vecs[6] = '{100, 1, 0, 99, 0};

    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; bin1 = 1'b0;
    tick();
    tick();
    check("rst_ready", ready8, 1);
    check("rst_busy", busy8, 0);
    check("rst_done", done8, 0);
    check("rst_diff", diff8, 0);
    check("rst_bo", bo8, 0);
    check("rst_ready_w1", ready1, 1);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) begin
      run_op(1'b0, vecs[i].a, vecs[i].b, vecs[i].bin, d, bo, lat, bcnt);
      check("vec_diff", d, vecs[i].exp_diff);
      check("vec_borrow", bo, vecs[i].exp_bo);
      check("vec_latency", lat, 9);
      check("vec_busy_cycles", bcnt, 8);
    end

    // start during RUN and DONE must be ignored; diff holds the previous result until DONE.
    run_op(1'b0, 200, 55, 0, d, bo, lat, bcnt);
    check("pre_diff", d, 145);
    tick();
    start8 = 1'b1; a8 = 8'd100; b8 = 8'd1; bin8 = 1'b0;
    tick();
    start8 = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      check("run_busy", busy8, 1);
      check("run_diff_hold", diff8, 145);
      check("run_no_done", done8, 0);
      start8 = (k == 3);
      a8 = 8'd7; b8 = 8'd3;
      tick();
    end
    start8 = 1'b0;
    check("ign_done", done8, 1);
    check("ign_diff", diff8, 99);
    check("ign_bo", bo8, 0);
    check("ign_done_ready", ready8, 0);
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    check("ign_idle_ready", ready8, 1);
    tick();
    check("ign_not_queued", busy8, 0);
    check("ign_diff_held", diff8, 99);
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done8) ndone++;
    end
    check("ign_single_done", ndone, 0);

    // Reset mid-RUN aborts without a done pulse and clears the outputs.
    start8 = 1'b1; a8 = 8'd9; b8 = 8'd4; bin8 = 1'b0;
    tick();
    start8 = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_ready", ready8, 1);
    check("abort_busy", busy8, 0);
    check("abort_done", done8, 0);
    check("abort_diff", diff8, 0);
    check("abort_bo", bo8, 0);
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done8) ndone++;
    end
    check("abort_no_done", ndone, 0);
    run_op(1'b0, 9, 4, 0, d, bo, lat, bcnt);
    check("after_abort_diff", d, 5);
    check("after_abort_bo", bo, 0);
    tick();

    // Back-to-back random operations with start held high.
    accepts = 0; dones = 0; last_acc = -1; cyc = 0;
    while (dones < 500 && cyc < 6000) begin
      start8 = (accepts < 500);
      if (ready8 && accepts < 500) begin
        a8   = 8'($urandom);
        b8   = 8'($urandom);
        bin8 = 1'($urandom_range(0, 1));
        ref_sub(8, int'(a8), int'(b8), int'(bin8), ed, ebo);
        q_d.push_back(ed);
        q_bo.push_back(ebo);
        if (last_acc >= 0) check("accept_spacing", cyc - last_acc, 10);
        last_acc = cyc;
        accepts++;
      end
      tick();
      cyc++;
      if (done8) begin
        if (q_d.size() == 0) begin
          check("spurious_done", 1, 0);
        end else begin
          ed  = q_d.pop_front();
          ebo = q_bo.pop_front();
          check("rand_diff", diff8, ed);
          check("rand_borrow", bo8, ebo);
        end
        dones++;
      end
    end
    start8 = 1'b0;
    check("rand_done_count", dones, 500);

    // WIDTH=1 instance: full-subtractor truth table.
    for (int i = 0; i < 8; i++) begin
      ref_sub(1, (i >> 2) & 1, (i >> 1) & 1, i & 1, ed, ebo);
      run_op(1'b1, (i >> 2) & 1, (i >> 1) & 1, i & 1, d, bo, lat, bcnt);
      check("w1_diff", d, ed);
      check("w1_borrow", bo, ebo);
      check("w1_latency", lat, 2);
      check("w1_busy_cycles", bcnt, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
